// File: rtl/gbt_sc_rx.sv
// gbt_sc_rx: receiver for the GBT serial-control dibit channel.
// It detects a start-of-frame dibit and shifts in 8 payload dibits ({addr, data}, MSB first).
// It then checks the tail dibit {parity, stop}.
// A good word goes out on a valid/ready handshake.
// A bad tail or a dropped word raises a one-cycle pulse and bumps the saturating error counter.
module gbt_sc_rx #(
   parameter int         CNT_W = 16,
   parameter logic [1:0] SOF   = 2'b01
) (
   input  logic             clk_ik,
   input  logic             rst_n_ia,
   input  logic             frame_en_i,
   input  logic [1:0]       sc_data_i,
   output logic [7:0]       addr_o,
   output logic [7:0]       data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             err_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] pkt_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] TAIL    = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]  state_q;
   logic [2:0]  dibit_cnt_q;
   logic [15:0] shift_q;

   logic tail_hit;
   logic tail_ok;
   logic good_tail;
   logic bad_tail;
   logic load_word;
   logic drop_word;

   // Tail evaluation and handshake decisions, all taken in the tail-dibit cycle
   always_comb begin
      tail_hit  = (state_q == TAIL) && frame_en_i;
      tail_ok   = (sc_data_i[1] == (^shift_q)) && sc_data_i[0];
      good_tail = tail_hit && tail_ok;
      bad_tail  = tail_hit && !tail_ok;
      load_word = good_tail && (!valid_o || ready_i);
      drop_word = good_tail && valid_o && !ready_i;
   end

   // Frame FSM: IDLE hunts for SOF, PAYLOAD collects 8 dibits, TAIL always returns to IDLE
   always_ff @(posedge clk_ik or negedge rst_n_ia) begin
      if (!rst_n_ia) begin
         state_q     <= IDLE;
         dibit_cnt_q <= 3'd0;
         shift_q     <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               dibit_cnt_q <= 3'd0;
               if (frame_en_i && (sc_data_i == SOF)) begin
                  state_q <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (!frame_en_i) begin
                  state_q     <= IDLE;
                  dibit_cnt_q <= 3'd0;
               end else begin
                  shift_q     <= {shift_q[13:0], sc_data_i};
                  dibit_cnt_q <= dibit_cnt_q + 3'd1;
                  if (dibit_cnt_q == 3'd7) begin
                     state_q <= TAIL;
                  end
               end
            end
            TAIL: begin
               state_q     <= IDLE;
               dibit_cnt_q <= 3'd0;
            end
            default: begin
               state_q     <= IDLE;
               dibit_cnt_q <= 3'd0;
            end
         endcase
      end
   end

   // Output word register and valid/ready handshake; a new load in the accept cycle keeps valid high
   always_ff @(posedge clk_ik or negedge rst_n_ia) begin
      if (!rst_n_ia) begin
         addr_o  <= 8'd0;
         data_o  <= 8'd0;
         valid_o <= 1'b0;
      end else if (load_word) begin
         addr_o  <= shift_q[15:8];
         data_o  <= shift_q[7:0];
         valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

   // Single-cycle error and overflow pulses
   always_ff @(posedge clk_ik or negedge rst_n_ia) begin
      if (!rst_n_ia) begin
         err_o <= 1'b0;
         ovf_o <= 1'b0;
      end else begin
         err_o <= bad_tail;
         ovf_o <= drop_word;
      end
   end

   // Saturating statistics counters; bad tails and dropped words share the error counter
   always_ff @(posedge clk_ik or negedge rst_n_ia) begin
      if (!rst_n_ia) begin
         pkt_cnt_o <= '0;
         err_cnt_o <= '0;
      end else begin
         if (load_word && (pkt_cnt_o != CNT_MAX)) begin
            pkt_cnt_o <= pkt_cnt_o + CNT_ONE;
         end
         if ((bad_tail || drop_word) && (err_cnt_o != CNT_MAX)) begin
            err_cnt_o <= err_cnt_o + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_gbt_sc_rx.sv
// tb_gbt_sc_rx: directed scenarios for the serial-control receiver.
// A second instance with 4-bit counters covers saturation.
module tb_gbt_sc_rx;

   logic       clk_ik;
   logic       rst_n_ia;
   logic       frame_en_i;
   logic [1:0] sc_data_i;
   logic       ready_i;

   logic [7:0]  addr_o, data_o;
   logic        valid_o, err_o, ovf_o;
   logic [15:0] pkt_cnt_o, err_cnt_o;

   logic [7:0] s_addr_o, s_data_o;
   logic       s_valid_o, s_err_o, s_ovf_o;
   logic [3:0] s_pkt_cnt_o, s_err_cnt_o;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int err_pulses = 0;
   logic [15:0] words[$];

   gbt_sc_rx #(.CNT_W(16), .SOF(2'b01)) dut (
      .clk_ik(clk_ik), .rst_n_ia(rst_n_ia), .frame_en_i(frame_en_i), .sc_data_i(sc_data_i),
      .addr_o(addr_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
      .err_o(err_o), .ovf_o(ovf_o), .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
   );

   gbt_sc_rx #(.CNT_W(4), .SOF(2'b01)) dut_sat (
      .clk_ik(clk_ik), .rst_n_ia(rst_n_ia), .frame_en_i(frame_en_i), .sc_data_i(sc_data_i),
      .addr_o(s_addr_o), .data_o(s_data_o), .valid_o(s_valid_o), .ready_i(ready_i),
      .err_o(s_err_o), .ovf_o(s_ovf_o), .pkt_cnt_o(s_pkt_cnt_o), .err_cnt_o(s_err_cnt_o)
   );

   // 40 MHz-style free-running clock
   initial begin
      clk_ik = 1'b0;
      forever #5 clk_ik = ~clk_ik;
   end

   // Observe pulses and accepted words halfway between active edges
   always @(negedge clk_ik) begin
      if (err_o === 1'b1) err_pulses++;
      if (valid_o === 1'b1 && ready_i === 1'b1) words.push_back({addr_o, data_o});
   end

   task automatic drive(input logic en, input logic [1:0] d);
      frame_en_i = en;
      sc_data_i  = d;
      @(posedge clk_ik);
      #1;
   endtask

   task automatic send_packet(input logic [7:0] a, input logic [7:0] d,
                              input logic flip_parity, input logic stop);
      logic [15:0] w;
      logic        p;
      w = {a, d};
      p = (^w) ^ flip_parity;
      drive(1'b1, 2'b01);
      for (int i = 0; i < 8; i++) drive(1'b1, w[15-2*i -: 2]);
      drive(1'b1, {p, stop});
      sc_data_i = 2'b11;
   endtask

   task automatic do_reset();
      rst_n_ia   = 1'b0;
      frame_en_i = 1'b0;
      sc_data_i  = 2'b11;
      ready_i    = 1'b0;
      repeat (2) @(posedge clk_ik);
      #1;
      rst_n_ia = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", valid_o); else pass_cnt++;
      total_cnt++; if (addr_o !== 8'h00 || data_o !== 8'h00) $display("[TB] FAIL reset_word got %h/%h want 00/00", addr_o, data_o); else pass_cnt++;
      total_cnt++; if (err_o !== 1'b0 || ovf_o !== 1'b0) $display("[TB] FAIL reset_pulses got %b%b want 00", err_o, ovf_o); else pass_cnt++;
      total_cnt++; if (pkt_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) $display("[TB] FAIL reset_cnts got %0d/%0d want 0/0", pkt_cnt_o, err_cnt_o); else pass_cnt++;
   endtask

   task automatic test_good_packet();
      int e0;
      do_reset();
      e0 = err_pulses;
      // 01, 01 01 10 10 11 00 00 11, 01
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b01); drive(1'b1, 2'b01); drive(1'b1, 2'b10); drive(1'b1, 2'b10);
      drive(1'b1, 2'b11); drive(1'b1, 2'b00); drive(1'b1, 2'b00); drive(1'b1, 2'b11);
      total_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL good_early_valid got %b want 0", valid_o); else pass_cnt++;
      drive(1'b1, 2'b01);
      sc_data_i = 2'b11;
      total_cnt++; if (valid_o !== 1'b1) $display("[TB] FAIL good_valid got %b want 1", valid_o); else pass_cnt++;
      total_cnt++; if (addr_o !== 8'h5A) $display("[TB] FAIL good_addr got %h want 5a", addr_o); else pass_cnt++;
      total_cnt++; if (data_o !== 8'hC3) $display("[TB] FAIL good_data got %h want c3", data_o); else pass_cnt++;
      total_cnt++; if (pkt_cnt_o !== 16'd1) $display("[TB] FAIL good_pkt_cnt got %0d want 1", pkt_cnt_o); else pass_cnt++;
      repeat (3) drive(1'b1, 2'b11);
      total_cnt++; if (valid_o !== 1'b1 || addr_o !== 8'h5A) $display("[TB] FAIL good_hold got %b/%h want 1/5a", valid_o, addr_o); else pass_cnt++;
      total_cnt++; if (err_pulses != e0) $display("[TB] FAIL good_no_err got %0d want 0", err_pulses - e0); else pass_cnt++;
   endtask

   task automatic test_parity_error();
      int e0;
      do_reset();
      e0 = err_pulses;
      send_packet(8'h5A, 8'hC3, 1'b1, 1'b1);
      total_cnt++; if (err_o !== 1'b1) $display("[TB] FAIL par_err_pulse got %b want 1", err_o); else pass_cnt++;
      total_cnt++; if (err_cnt_o !== 16'd1) $display("[TB] FAIL par_err_cnt got %0d want 1", err_cnt_o); else pass_cnt++;
      drive(1'b1, 2'b11);
      drive(1'b1, 2'b11);
      total_cnt++; if (err_pulses - e0 != 1) $display("[TB] FAIL par_err_once got %0d want 1", err_pulses - e0); else pass_cnt++;
      total_cnt++; if (valid_o !== 1'b0 || pkt_cnt_o !== 16'd0) $display("[TB] FAIL par_no_word got %b/%0d want 0/0", valid_o, pkt_cnt_o); else pass_cnt++;
      send_packet(8'h5A, 8'hC3, 1'b0, 1'b0);
      total_cnt++; if (err_o !== 1'b1 || err_cnt_o !== 16'd2) $display("[TB] FAIL stop_err got %b/%0d want 1/2", err_o, err_cnt_o); else pass_cnt++;
      total_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL stop_no_word got %b want 0", valid_o); else pass_cnt++;
   endtask

   task automatic test_overflow();
      do_reset();
      send_packet(8'h5A, 8'hC3, 1'b0, 1'b1);
      drive(1'b1, 2'b11);
      send_packet(8'h01, 8'h02, 1'b0, 1'b1);
      total_cnt++; if (ovf_o !== 1'b1) $display("[TB] FAIL ovf_pulse got %b want 1", ovf_o); else pass_cnt++;
      total_cnt++; if (err_o !== 1'b0) $display("[TB] FAIL ovf_no_err got %b want 0", err_o); else pass_cnt++;
      total_cnt++; if (addr_o !== 8'h5A || data_o !== 8'hC3 || valid_o !== 1'b1) $display("[TB] FAIL ovf_word got %b %h/%h want 1 5a/c3", valid_o, addr_o, data_o); else pass_cnt++;
      total_cnt++; if (err_cnt_o !== 16'd1 || pkt_cnt_o !== 16'd1) $display("[TB] FAIL ovf_cnts got %0d/%0d want 1/1", err_cnt_o, pkt_cnt_o); else pass_cnt++;
      drive(1'b1, 2'b11);
      total_cnt++; if (ovf_o !== 1'b0) $display("[TB] FAIL ovf_one_cycle got %b want 0", ovf_o); else pass_cnt++;
      ready_i = 1'b1;
      drive(1'b1, 2'b11);
      ready_i = 1'b0;
      total_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL ovf_drain got %b want 0", valid_o); else pass_cnt++;
   endtask

   task automatic test_abort();
      int e0;
      int w0;
      do_reset();
      e0 = err_pulses;
      w0 = words.size();
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b10); drive(1'b1, 2'b10); drive(1'b1, 2'b10); drive(1'b1, 2'b11);
      drive(1'b0, 2'b11);
      total_cnt++; if (pkt_cnt_o !== 16'd0 || err_cnt_o !== 16'd0 || valid_o !== 1'b0) $display("[TB] FAIL abort_quiet got %0d/%0d/%b want 0/0/0", pkt_cnt_o, err_cnt_o, valid_o); else pass_cnt++;
      send_packet(8'h10, 8'h20, 1'b0, 1'b1);
      total_cnt++; if (valid_o !== 1'b1 || addr_o !== 8'h10 || data_o !== 8'h20) $display("[TB] FAIL abort_word got %b %h/%h want 1 10/20", valid_o, addr_o, data_o); else pass_cnt++;
      total_cnt++; if (pkt_cnt_o !== 16'd1 || err_cnt_o !== 16'd0) $display("[TB] FAIL abort_cnts got %0d/%0d want 1/0", pkt_cnt_o, err_cnt_o); else pass_cnt++;
      ready_i = 1'b1;
      drive(1'b1, 2'b11);
      ready_i = 1'b0;
      total_cnt++; if (words.size() - w0 != 1 || err_pulses != e0) $display("[TB] FAIL abort_delivered got %0d words %0d errs want 1/0", words.size() - w0, err_pulses - e0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int w0;
      do_reset();
      ready_i = 1'b1;
      w0 = words.size();
      send_packet(8'h11, 8'h22, 1'b0, 1'b1);
      send_packet(8'hA5, 8'h0F, 1'b0, 1'b1);
      send_packet(8'h7F, 8'h00, 1'b0, 1'b1);
      total_cnt++; if (valid_o !== 1'b1 || addr_o !== 8'h7F || data_o !== 8'h00) $display("[TB] FAIL b2b_last got %b %h/%h want 1 7f/00", valid_o, addr_o, data_o); else pass_cnt++;
      drive(1'b1, 2'b11);
      total_cnt++; if (words.size() - w0 != 3) $display("[TB] FAIL b2b_count got %0d want 3", words.size() - w0); else pass_cnt++;
      if (words.size() - w0 == 3) begin
         total_cnt++; if (words[w0] !== 16'h1122) $display("[TB] FAIL b2b_w0 got %h want 1122", words[w0]); else pass_cnt++;
         total_cnt++; if (words[w0+1] !== 16'hA50F) $display("[TB] FAIL b2b_w1 got %h want a50f", words[w0+1]); else pass_cnt++;
         total_cnt++; if (words[w0+2] !== 16'h7F00) $display("[TB] FAIL b2b_w2 got %h want 7f00", words[w0+2]); else pass_cnt++;
      end
      total_cnt++; if (pkt_cnt_o !== 16'd3 || valid_o !== 1'b0) $display("[TB] FAIL b2b_pkt_cnt got %0d/%b want 3/0", pkt_cnt_o, valid_o); else pass_cnt++;
      // Reset in the middle of a packet, between clock edges
      drive(1'b1, 2'b01);
      drive(1'b1, 2'b00); drive(1'b1, 2'b11);
      #2;
      rst_n_ia = 1'b0;
      #1;
      total_cnt++; if (pkt_cnt_o !== 16'd0 || addr_o !== 8'h00 || data_o !== 8'h00 || valid_o !== 1'b0) $display("[TB] FAIL mid_reset got %0d %h/%h %b want 0 00/00 0", pkt_cnt_o, addr_o, data_o, valid_o); else pass_cnt++;
      @(posedge clk_ik);
      #1;
      rst_n_ia = 1'b1;
      drive(1'b1, 2'b11); drive(1'b1, 2'b11); drive(1'b1, 2'b11);
      send_packet(8'h3C, 8'hC3, 1'b0, 1'b1);
      total_cnt++; if (valid_o !== 1'b1 || addr_o !== 8'h3C || data_o !== 8'hC3) $display("[TB] FAIL post_reset_word got %b %h/%h want 1 3c/c3", valid_o, addr_o, data_o); else pass_cnt++;
      total_cnt++; if (pkt_cnt_o !== 16'd1 || err_cnt_o !== 16'd0) $display("[TB] FAIL post_reset_cnts got %0d/%0d want 1/0", pkt_cnt_o, err_cnt_o); else pass_cnt++;
      ready_i = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 17; i++) send_packet(8'h5A, 8'hC3, 1'b1, 1'b1);
      drive(1'b1, 2'b11);
      total_cnt++; if (s_err_cnt_o !== 4'd15) $display("[TB] FAIL sat_err_cnt got %0d want 15", s_err_cnt_o); else pass_cnt++;
      total_cnt++; if (err_cnt_o !== 16'd17) $display("[TB] FAIL wide_err_cnt got %0d want 17", err_cnt_o); else pass_cnt++;
      total_cnt++; if (s_pkt_cnt_o !== 4'd0 || s_valid_o !== 1'b0) $display("[TB] FAIL sat_pkt_cnt got %0d/%b want 0/0", s_pkt_cnt_o, s_valid_o); else pass_cnt++;
   endtask

   // Scenario sequence
   initial begin
      rst_n_ia   = 1'b1;
      frame_en_i = 1'b0;
      sc_data_i  = 2'b11;
      ready_i    = 1'b0;
      test_reset();
      test_good_packet();
      test_parity_error();
      test_overflow();
      test_abort();
      test_back_to_back();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/gbt_sc_rx.md
GBT_SC_RX -- requirements
Module: gbt_sc_rx

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the packet and error counters.
REQ-002 SHALL have parameter SOF, default 2'b01: start-of-frame dibit.
REQ-003 SHALL have port clk_ik, input, 1: single clock, 40 MHz GBT frame clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_ia, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port frame_en_i, input, 1: GBT RX ready; the sc_data dibit is valid only while this is high.
REQ-006 SHALL have port sc_data_i, input, 2: serial-control dibit, one per frame; idle line = 2'b11.
REQ-007 SHALL have port addr_o, output, 8: received address.
REQ-008 SHALL have port data_o, output, 8: received data.
REQ-009 SHALL have port valid_o, output, 1: addr_o/data_o hold a word.
REQ-010 SHALL have port ready_i, input, 1: consumer accepts the word.
REQ-011 SHALL have port err_o, output, 1: one-cycle pulse on a parity or stop error.
REQ-012 SHALL have port ovf_o, output, 1: one-cycle pulse when a good word is dropped.
REQ-013 SHALL have port pkt_cnt_o, output, CNT_W: count of good words.
REQ-014 SHALL have port err_cnt_o, output, CNT_W: count of errors plus overflows.

Function
REQ-015 Packet on the wire, in order:
- SOF dibit.
- 8 payload dibits, MSB first: {addr[7:0], data[7:0]}; dibit bit1 precedes bit0.
- Tail dibit {P, S}: P = even parity (XOR of the 16 payload bits), S = stop bit, which SHALL be 1.
REQ-016 FSM states SHALL be IDLE, PAYLOAD, TAIL.
REQ-017 IDLE -> PAYLOAD when frame_en_i=1 and sc_data_i==SOF; any other dibit keeps IDLE.
REQ-018 PAYLOAD SHALL shift in one dibit per enabled cycle using a 3-bit dibit counter (0..7); after count 7 -> TAIL.
REQ-019 TAIL SHALL sample the tail dibit and -> IDLE on the same edge.
REQ-020 A SOF dibit arriving in the cycle directly after the tail SHALL start a new packet; back-to-back packets need no idle gap.
REQ-021 frame_en_i=0 in PAYLOAD or TAIL SHALL abort to IDLE: packet discarded, no err_o, counters unchanged.
REQ-022 Good tail (P correct, S=1):
- If valid_o=0, or valid_o=1 and ready_i=1 in that cycle: load addr_o/data_o, valid_o=1 from the next cycle, pkt_cnt_o+1. Latency is one cycle from the tail-dibit edge to valid_o.
- If valid_o=1 and ready_i=0: drop the word, pulse ovf_o, err_cnt_o+1; addr_o/data_o/valid_o unchanged.
REQ-023 Bad tail (parity mismatch or S=0): discard the packet, pulse err_o, err_cnt_o+1; valid_o unaffected.
REQ-024 Handshake:
- valid_o SHALL remain high, with addr_o/data_o stable, until a cycle with ready_i=1.
- valid_o SHALL clear after that cycle unless a new word loads in the same cycle, in which case valid_o stays 1 with the new data.
REQ-025 Counters SHALL saturate at all-ones, not wrap; err_cnt_o and pkt_cnt_o increment independently.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Assertion of rst_n_ia SHALL force the following immediately, regardless of clock: FSM=IDLE, dibit counter=0, shift register=0, addr_o=0, data_o=0, valid_o=0, err_o=0, ovf_o=0, pkt_cnt_o=0, err_cnt_o=0.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet; after deassertion the block SHALL wait for a fresh SOF.
REQ-029 Deassertion SHALL be synchronized externally; the block needs no internal reset synchronizer.

Verification
REQ-030 Good packet: frame_en_i=1, ready_i=0, dibits 01, 01 01 10 10 11 00 00 11, 01 (addr 0x5A, data 0xC3, P=0) -> one cycle after the tail, valid_o=1, addr_o=0x5A, data_o=0xC3, pkt_cnt_o=1, err_o never pulses.
REQ-031 Parity error: same packet with tail 11 -> err_o pulses once, err_cnt_o=1, valid_o stays 0.
REQ-032 Overflow: deliver 0x5A/0xC3 and hold ready_i=0, then send a good packet 0x01/0x02 -> ovf_o pulses, outputs still 0x5A/0xC3, err_cnt_o=1. Then ready_i=1 for one cycle -> valid_o=0.
REQ-033 Abort: drop frame_en_i for one cycle after the 4th payload dibit, then send a good packet 0x10/0x20 -> only 0x10/0x20 delivered, err_cnt_o=0.
REQ-034 Back-to-back with ready_i tied 1: three packets with no gap -> three valid_o pulses with correct words, pkt_cnt_o=3. Asserting rst_n_ia mid-packet clears all outputs; the next full packet decodes correctly.
REQ-035 Saturation: with CNT_W=4, send 17 bad packets -> err_cnt_o holds at 15.
